// File: rtl/axi_mem_port_arbiter.sv
// rtl/axi_mem_port_arbiter.sv - round-robin arbiter sharing one SRAM port between AXI write and read controllers
// Optional burst lock: define AXI_MEM_ARB_BURST_LOCK_EN.
module axi_mem_port_arbiter #(
    parameter int MEM_ADDR_WIDTH = 13,
    parameter int DATA_WIDTH     = 64,
    parameter int NUMBYTES       = DATA_WIDTH / 8,
    parameter int MAX_LOCK_BEATS = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      W_valid_i,
    output logic                      W_grant_o,
    input  logic                      W_CEN_i,
    input  logic                      W_WEN_i,
    input  logic [MEM_ADDR_WIDTH-1:0] W_A_i,
    input  logic [DATA_WIDTH-1:0]     W_D_i,
    input  logic [NUMBYTES-1:0]       W_BE_i,
    input  logic                      R_valid_i,
    output logic                      R_grant_o,
    input  logic                      R_CEN_i,
    input  logic                      R_WEN_i,
    input  logic [MEM_ADDR_WIDTH-1:0] R_A_i,
    output logic [DATA_WIDTH-1:0]     R_Q_o,
    output logic                      R_rvalid_o,
    output logic                      MEM_CEN_o,
    output logic                      MEM_WEN_o,
    output logic [MEM_ADDR_WIDTH-1:0] MEM_A_o,
    output logic [DATA_WIDTH-1:0]     MEM_D_o,
    output logic [NUMBYTES-1:0]       MEM_BE_o,
    input  logic [DATA_WIDTH-1:0]     MEM_Q_i
);

    if (MAX_LOCK_BEATS < 1 || MAX_LOCK_BEATS > 256) begin : g_bad_lock_beats
        $error("MAX_LOCK_BEATS out of range 1..256");
    end

    logic                  last_w_q, last_w_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [DATA_WIDTH-1:0] q_hold_q, q_hold_d;
    logic                  w_wins;

    // The read port never writes the SRAM, so its write enable is ignored.
    logic unused_r_wen;
    assign unused_r_wen = R_WEN_i;

`ifdef AXI_MEM_ARB_BURST_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK_BEATS + 1);

    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          lock_hold;

    // A zero count means the owner went idle, which releases the lock.
    assign lock_hold = (lock_cnt_q != '0) && (lock_cnt_q < CW'(MAX_LOCK_BEATS));

    always_comb begin
        w_wins = lock_hold ? last_w_q : ~last_w_q;
    end

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (!W_grant_o && !R_grant_o) begin
            lock_cnt_d = '0;
        end else if (W_grant_o != last_w_q) begin
            lock_cnt_d = CW'(1);
        end else if (lock_cnt_q != CW'(MAX_LOCK_BEATS)) begin
            lock_cnt_d = lock_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    always_comb begin
        w_wins = ~last_w_q;
    end
`endif

    always_comb begin
        W_grant_o = W_valid_i & (~R_valid_i | w_wins);
        R_grant_o = R_valid_i & ~(W_valid_i & w_wins);
    end

    always_comb begin
        MEM_CEN_o = 1'b1;
        MEM_WEN_o = 1'b1;
        MEM_A_o   = W_A_i;
        MEM_D_o   = W_D_i;
        MEM_BE_o  = W_BE_i;
        if (W_grant_o) begin
            MEM_CEN_o = W_CEN_i;
            MEM_WEN_o = W_WEN_i;
        end else if (R_grant_o) begin
            MEM_CEN_o = R_CEN_i;
            MEM_A_o   = R_A_i;
        end
    end

    always_comb begin
        last_w_d  = last_w_q;
        if (W_grant_o) begin
            last_w_d = 1'b1;
        end else if (R_grant_o) begin
            last_w_d = 1'b0;
        end
        rd_pend_d = R_grant_o & ~R_CEN_i;
        q_hold_d  = rd_pend_q ? MEM_Q_i : q_hold_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_w_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            q_hold_q  <= '0;
        end else begin
            last_w_q  <= last_w_d;
            rd_pend_q <= rd_pend_d;
            q_hold_q  <= q_hold_d;
        end
    end

    // Fresh SRAM data passes straight through; otherwise the last read result is held.
    assign R_rvalid_o = rd_pend_q;
    assign R_Q_o      = rd_pend_q ? MEM_Q_i : q_hold_q;

endmodule

// File: doc/axi_mem_port_arbiter.md
# axi_mem_port_arbiter

Two-requester arbiter sharing one single-port SRAM between the AXI write-only controller and the AXI read-only controller of the memory interface. It muxes their memory-port requests using round-robin priority and returns grants. It also tracks the one-cycle SRAM read latency, so read data reaches the read controller with a valid strobe and stays stable while the port serves writes.

## Interface
- MEM_ADDR_WIDTH, 13, SRAM word-address width
- DATA_WIDTH, 64, SRAM data width
- NUMBYTES, DATA_WIDTH/8, byte-enable width
- MAX_LOCK_BEATS, 16, maximum consecutive grants to one requester when burst lock is compiled in; legal range is 1..256
- clk  in  1  clock; all logic samples on the rising edge
- rst_n  in  1  asynchronous reset, active low
- W_valid_i  in  1  write controller requests the port this cycle
- W_grant_o  out  1  write request granted this cycle
- W_CEN_i / W_WEN_i  in  1 / 1  write-side chip enable (active low) and write enable (0 = write)
- W_A_i  in  MEM_ADDR_WIDTH  write-side address
- W_D_i  in  DATA_WIDTH  write-side data
- W_BE_i  in  NUMBYTES  write-side byte enables
- R_valid_i  in  1  read controller requests the port this cycle
- R_grant_o  out  1  read request granted this cycle
- R_CEN_i / R_WEN_i  in  1 / 1  read-side chip enable and write enable
- R_A_i  in  MEM_ADDR_WIDTH  read-side address
- R_Q_o  out  DATA_WIDTH  read data returned to the read controller
- R_rvalid_o  out  1  R_Q_o carries fresh data for the previous granted read
- MEM_CEN_o, MEM_WEN_o, MEM_A_o, MEM_D_o, MEM_BE_o  out  1, 1, MEM_ADDR_WIDTH, DATA_WIDTH, NUMBYTES  SRAM port
- MEM_Q_i  in  DATA_WIDTH  SRAM read data, valid one cycle after a read access

## Operation
- **Grant logic:** grants are combinational from the valids and the priority state. At most one of W_grant_o / R_grant_o is high in any cycle. A grant is never issued without the matching valid.
- **Single requester:** if only one valid is high, that requester is granted.
- **Both valid:** the requester not granted most recently wins.
- **Priority state:** register last_w (1 = write was last granted). It updates only in cycles where a grant is issued.
- **Port mux:**
  - Granted side drives MEM_CEN_o = side CEN, MEM_WEN_o = side WEN, and the side's MEM_A_o.
  - With no grant, MEM_CEN_o = 1, MEM_WEN_o = 1, and address/data/BE hold the write-side values.
  - MEM_D_o = W_D_i and MEM_BE_o = W_BE_i always.
  - The read side forces MEM_WEN_o = 1 regardless of R_WEN_i.
- **Read tracking:**
  - rd_pend register ← R_grant_o & ~R_CEN_i.
  - R_rvalid_o = rd_pend.
  - When rd_pend = 1: R_Q_o = MEM_Q_i, and q_hold ← MEM_Q_i.
  - When rd_pend = 0: R_Q_o = q_hold.
- **Register reset values:** last_w = 0, so write wins the first conflict; rd_pend = 0; q_hold = 0; lock_cnt = 0.
- **Output reset values:**
  - W_grant_o and R_grant_o follow their valids; with both valids low they are 0.
  - MEM_CEN_o = 1, MEM_WEN_o = 1.
  - R_rvalid_o = 0, R_Q_o = 0.
- **Reset mid-access:** an in-flight read is dropped; no R_rvalid_o pulse follows reset.

## Timing
- Grant-to-SRAM access: 0 cycles, in the same cycle as the grant.
- Granted read at cycle t: R_rvalid_o = 1 and R_Q_o = MEM_Q_i at t+1. R_Q_o holds that value from t+2 until the next granted read completes.
- **Back-to-back reads:** R_rvalid_o stays high on consecutive cycles.
- **Write at t+1 after a read at t:** R_Q_o at t+1 is still the read data.
- **Simultaneous valids:** the loser sees grant = 0, keeps valid asserted, and wins the next cycle unless the lock below applies.
- **Combinational paths:** valid→grant is combinational. Requesters must not make valid depend on grant.

## Configuration
- Macro: AXI_MEM_ARB_BURST_LOCK_EN.
- **Defined:**
  - lock_cnt counts consecutive grants to the current owner.
  - While the owner keeps valid high and lock_cnt < MAX_LOCK_BEATS, the owner keeps winning conflicts.
  - The lock releases when lock_cnt reaches MAX_LOCK_BEATS (the other requester is then granted) or when the owner drops valid for one cycle.
  - lock_cnt resets to 1 on an ownership change and to 0 on an idle cycle.
- **Undefined:** pure per-beat round robin; lock_cnt is absent and MAX_LOCK_BEATS is ignored.

## Test plan
- **Reset:** after reset with both valids high → W_grant_o = 1 first. Then, with both held high, grants alternate R, W, R each cycle (lock undefined).
- **Read-only:** read of A=0x010 granted at t, MEM_Q_i = 0xDEAD_BEEF at t+1 → R_rvalid_o = 1 at t+1. A write is granted at t+2 → R_Q_o stays 0xDEAD_BEEF with R_rvalid_o = 0.
- **Write-only:** W_A_i = 0x1F, W_D_i = 0x55, W_BE_i = 0xFF, W_WEN_i = 0 → MEM_CEN_o = 0, MEM_WEN_o = 0, MEM_A_o = 0x1F in the same cycle.
- **Read-side write enable:** R_WEN_i = 0 on a granted read → MEM_WEN_o = 1.
- **Burst lock:** lock defined, MAX_LOCK_BEATS = 4, write valid continuous, read valid from cycle 1 → exactly 4 write grants, then 1 read grant.
- **Reset mid-access:** assert rst_n low in the cycle after a granted read → R_rvalid_o = 0, R_Q_o = 0.
